fifo_uart_tx: RTL

- Downstream consumer of the team's show-ahead FIFO (head word visible on its dataout whenever val=1; read pops it).
- Pops one word per frame and serialises it onto a single UART-style line: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
- Bit timing comes from an internal baud counter.
- Sits between the FIFO and the chip's serial output pad.

---
 rtl/fifo_uart_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// Pops words from a show-ahead FIFO and serialises each as start, data (LSB first), optional parity, stop bits.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_val,
  output logic                  fifo_read,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [BAUD_W-1:0]     r_baud, w_baud_nxt;
  logic [BIT_W-1:0]      r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_txd, w_txd_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity, w_parity_nxt;
`endif

  logic w_baud_last;
  logic w_stop_end;

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_stop_end  = (r_state == S_STOP) && w_baud_last && (r_bit == STOP_LAST);

  // Pop only when idle or in the final stop cycle, so consecutive frames abut
  assign fifo_read = fifo_val & enable & reset & ((r_state == S_IDLE) | w_stop_end);

  assign txd  = r_txd;
  assign busy = r_busy;
  assign done = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_last ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    w_txd_nxt   = 1'b1;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            w_bit_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_state_nxt = S_STOP;
          w_bit_nxt   = '0;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          if (r_bit == STOP_LAST) w_state_nxt = S_IDLE;
          else                    w_bit_nxt   = r_bit + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (fifo_read) begin
      w_state_nxt = S_START;
      w_shift_nxt = fifo_data;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
      w_parity_nxt = ^fifo_data;
`endif
    end

    // Line level and flags are registered from the upcoming state
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = w_parity_nxt;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST) && (w_bit_nxt == STOP_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

endmodule
